// File: rtl/nyq_fir_dec.sv
// Time-multiplexed Nyquist FIR decimator: one shared signed MAC walks all taps
// per output, then rounds half-up and saturates into the output register.
module nyq_fir_dec #(
  parameter int NUM_TAPS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int COEF_WIDTH = 24,
  parameter int IN_WIDTH   = 24,
  parameter int OUT_WIDTH  = 24,
  parameter int ACC_WIDTH  = 56,
  parameter int FRAC_BITS  = 23
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  WrEn_SI,
  input  logic [ADDR_WIDTH-1:0] Addr_DI,
  input  logic [COEF_WIDTH-1:0] PAR_In_DI,
  input  logic [1:0]            Dec_DI,
  input  logic                  Clr_SI,
  input  logic                  In_Valid_SI,
  output logic                  In_Ready_SO,
  input  logic [IN_WIDTH-1:0]   NYQ_In_DI,
  output logic [OUT_WIDTH-1:0]  NYQ_Out_DO,
  output logic                  Out_Valid_SO,
  output logic                  Busy_SO
);

  localparam int PW = IN_WIDTH + COEF_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] RND =
    {{(ACC_WIDTH-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                             state, state_nxt;
  logic [NUM_TAPS-1:0][IN_WIDTH-1:0]   dly;
  logic [NUM_TAPS-1:0][COEF_WIDTH-1:0] coef;
  logic [1:0]                          phase;
  logic [ADDR_WIDTH-1:0]               idx;
  logic signed [ACC_WIDTH-1:0]         acc;

  logic                        accept, fire, last_tap;
  logic [IN_WIDTH-1:0]         x_cur;
  logic [COEF_WIDTH-1:0]       c_cur;
  logic [PW-1:0]               prod;
  logic signed [ACC_WIDTH-1:0] prod_ext, acc_rnd, acc_sh;
  logic [OUT_WIDTH-1:0]        sat;

  assign In_Ready_SO = (state == IDLE);
  assign Busy_SO     = (state != IDLE);
  assign accept      = In_Valid_SI & In_Ready_SO & ~Clr_SI;
  // >= rather than == so a live shrink of Dec_DI fires on the next accept
  assign fire        = accept & (phase >= Dec_DI);
  assign last_tap    = (idx == ADDR_WIDTH'(NUM_TAPS-1));

  // Sign-extending both operands to PW bits makes the low PW bits of the
  // unsigned product equal the full signed product.
  assign x_cur    = dly[idx];
  assign c_cur    = coef[idx];
  assign prod     = {{COEF_WIDTH{x_cur[IN_WIDTH-1]}}, x_cur} *
                    {{IN_WIDTH{c_cur[COEF_WIDTH-1]}}, c_cur};
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
  assign acc_rnd  = acc + RND;
  assign acc_sh   = acc_rnd >>> FRAC_BITS;

  always_comb begin
    sat = acc_sh[OUT_WIDTH-1:0];
    if (acc_sh > SAT_MAX)      sat = SAT_MAX[OUT_WIDTH-1:0];
    else if (acc_sh < SAT_MIN) sat = SAT_MIN[OUT_WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (Clr_SI) state_nxt = IDLE;
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state        <= IDLE;
      dly          <= '0;
      coef         <= '0;
      phase        <= '0;
      idx          <= '0;
      acc          <= '0;
      NYQ_Out_DO   <= '0;
      Out_Valid_SO <= 1'b0;
    end else begin
      state        <= state_nxt;
      Out_Valid_SO <= 1'b0;
      if (Clr_SI) begin
        dly   <= '0;
        phase <= '0;
        idx   <= '0;
        acc   <= '0;
      end else begin
        if (state == IDLE && WrEn_SI) coef[Addr_DI] <= PAR_In_DI;
        case (state)
          IDLE: if (accept) begin
            dly <= {dly[NUM_TAPS-2:0], NYQ_In_DI};
            if (fire) begin
              phase <= '0;
              acc   <= '0;
              idx   <= '0;
            end else begin
              phase <= phase + 2'd1;
            end
          end
          MAC: begin
            acc <= acc + prod_ext;
            idx <= idx + ADDR_WIDTH'(1);
          end
          OUT: begin
            NYQ_Out_DO   <= sat;
            Out_Valid_SO <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
